// File: rtl/conversor_bin_bcd.sv
`default_nettype none
// ============================================================================
// Module   : conversor_bin_bcd
// Purpose  : Sequential binary-to-BCD converter using shift-and-add-3
//            (double dabble), one shift per clock, start/done handshake.
//            Takes the N_BITS-wide product from the multiplier stage and
//            produces three registered BCD digits for the display stage.
// Ports    : clk       - system clock, rising edge
//            reset     - asynchronous, active-high reset
//            start     - conversion request, sampled only in IDLE
//            bin       - unsigned binary operand [N_BITS-1:0]
//            centenas  - hundreds digit (registered)
//            dezenas   - tens digit (registered)
//            unidades  - units digit (registered)
//            busy      - high while a conversion is in flight
//            done      - one-cycle pulse when new digits are valid
// Params   : N_BITS    - operand width, 4..8
// Macro    : SUPRESSAO_ZEROS_EN - when defined, leading zeros are blanked
//            to 4'hF (segments off) as the output registers are loaded.
// Revision : 1.0 - initial release
// ============================================================================
module conversor_bin_bcd #(
   parameter int N_BITS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_BITS-1:0] bin,
   output logic [3:0]        centenas,
   output logic [3:0]        dezenas,
   output logic [3:0]        unidades,
   output logic              busy,
   output logic              done
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Shift count of the final iteration; completion happens on this edge.
   localparam logic [3:0] CNT_LAST = 4'(N_BITS - 1);

`ifdef SUPRESSAO_ZEROS_EN
   localparam logic [3:0] RST_CEN = 4'hF;
   localparam logic [3:0] RST_DEZ = 4'hF;
`else
   localparam logic [3:0] RST_CEN = 4'h0;
   localparam logic [3:0] RST_DEZ = 4'h0;
`endif
   localparam logic [3:0] RST_UNI = 4'h0;

   state_t            state_q, state_d;
   logic [N_BITS-1:0] sr_q, sr_d;
   logic [11:0]       bcd_q, bcd_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        cen_q, cen_d;
   logic [3:0]        dez_q, dez_d;
   logic [3:0]        uni_q, uni_d;
   logic              done_q, done_d;

   logic [11:0]       bcd_adj;
   logic [11:0]       bcd_shift;
   logic [N_BITS-1:0] sr_shift;

   // Add-3 correction per nibble, applied before the shift so that a
   // nibble >= 5 carries correctly into the next decade after doubling.
   // Nibbles are adjusted independently; no carry crosses nibbles.
   genvar i;
   generate
      for (i = 0; i < 3; i++) begin : g_adj
         assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                                    (bcd_q[4*i +: 4] + 4'd3) :
                                     bcd_q[4*i +: 4];
      end
   endgenerate

   // {bcd, sr} shifted left as one long register: MSB of sr feeds bcd[0].
   assign bcd_shift = (bcd_adj << 1) | {11'b0, sr_q[N_BITS-1]};
   assign sr_shift  = sr_q << 1;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      cen_d   = cen_q;
      dez_d   = dez_q;
      uni_d   = uni_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = bin;
               bcd_d   = 12'd0;
               cnt_d   = 4'd0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            sr_d  = sr_shift;
            bcd_d = bcd_shift;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               // Final digits come straight from this cycle's shifted
               // scratch, so they are valid in the same cycle as done.
`ifdef SUPRESSAO_ZEROS_EN
               cen_d = (bcd_shift[11:8] == 4'd0) ? 4'hF : bcd_shift[11:8];
               dez_d = (bcd_shift[11:4] == 8'd0) ? 4'hF : bcd_shift[7:4];
`else
               cen_d = bcd_shift[11:8];
               dez_d = bcd_shift[7:4];
`endif
               uni_d   = bcd_shift[3:0];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         bcd_q   <= 12'd0;
         cnt_q   <= 4'd0;
         cen_q   <= RST_CEN;
         dez_q   <= RST_DEZ;
         uni_q   <= RST_UNI;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         cen_q   <= cen_d;
         dez_q   <= dez_d;
         uni_q   <= uni_d;
         done_q  <= done_d;
      end
   end

   assign centenas = cen_q;
   assign dezenas  = dez_q;
   assign unidades = uni_q;
   assign done     = done_q;
   assign busy     = (state_q == SHIFT);

endmodule
`default_nettype wire
